// File: rtl/button_pulse_conditioner_pkg.sv
// Shared stopwatch board constants: clock rate, debounce timing and the
// button debounce state encoding used by every button conditioner instance.
package button_pulse_conditioner_pkg;

    localparam int CLK_HZ      = 50_000_000;
    localparam int DEBOUNCE_MS = 10;

    // Cycles needed to cover a debounce window of 'ms' milliseconds at 'clk_hz'.
    function automatic int debounce_cycles_for(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

    localparam int DEFAULT_DEBOUNCE_CYCLES = debounce_cycles_for(CLK_HZ, DEBOUNCE_MS);

    localparam logic [1:0] BTN_ST_IDLE         = 2'd0;
    localparam logic [1:0] BTN_ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] BTN_ST_PRESSED      = 2'd2;
    localparam logic [1:0] BTN_ST_RELEASE_WAIT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE         = BTN_ST_IDLE,
        ST_PRESS_WAIT   = BTN_ST_PRESS_WAIT,
        ST_PRESSED      = BTN_ST_PRESSED,
        ST_RELEASE_WAIT = BTN_ST_RELEASE_WAIT
    } btn_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs; both stages clear to 0
// on a synchronous active-low reset.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_d;
            r_sync2 <= r_sync1;
        end
    end

    assign o_q = r_sync2;

endmodule

// File: rtl/button_pulse_conditioner.sv
// Raw push-button to clean events: polarity normalise, synchronise, then
// debounce into one-cycle press/release pulses and a registered level.
module button_pulse_conditioner
    import button_pulse_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit ACTIVE_LOW_BTN  = 1'b0,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn_raw,
    output logic o_press_pulse,
    output logic o_release_pulse,
    output logic o_btn_level
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             w_btn_norm;
    logic             w_btn_sync;
    btn_state_t       r_state;
    btn_state_t       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_press;
    logic             w_press_next;
    logic             r_release;
    logic             w_release_next;
    logic             r_level;
    logic             w_level_next;

    // Inverting ahead of the synchroniser keeps everything downstream active-high.
    assign w_btn_norm = i_btn_raw ^ ACTIVE_LOW_BTN;

    sync_2ff u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (w_btn_norm),
        .o_q     (w_btn_sync)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_level   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_press   <= w_press_next;
            r_release <= w_release_next;
            r_level   <= w_level_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_press_next   = 1'b0;
        w_release_next = 1'b0;
        w_level_next   = r_level;

        case (r_state)
            ST_IDLE: begin
                if (w_btn_sync) begin
                    w_state_next = ST_PRESS_WAIT;
                    w_cnt_next   = '0;
                end
            end

            ST_PRESS_WAIT: begin
                if (!w_btn_sync) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = ST_PRESSED;
                    w_press_next = 1'b1;
                    w_level_next = 1'b1;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end

            ST_PRESSED: begin
                if (!w_btn_sync) begin
                    w_state_next = ST_RELEASE_WAIT;
                    w_cnt_next   = '0;
                end
            end

            ST_RELEASE_WAIT: begin
                // A single high sample during release qualification is treated as bounce.
                if (w_btn_sync) begin
                    w_state_next = ST_PRESSED;
                    w_cnt_next   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next   = ST_IDLE;
                    w_release_next = 1'b1;
                    w_level_next   = 1'b0;
                    w_cnt_next     = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end

            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
                w_level_next = 1'b0;
            end
        endcase
    end

    assign o_press_pulse   = r_press;
    assign o_release_pulse = r_release;
    assign o_btn_level     = r_level;

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Directed bench for button_pulse_conditioner: expected pulse events are queued
// with their due edge when stimulus is driven and matched as the DUTs emit them.
module tb_button_pulse_conditioner;

    typedef enum int {EV_NONE = 0, EV_PRESS = 1, EV_RELEASE = 2} evKind_t;

    typedef struct {
        evKind_t kind;
        int      edgeNum;
    } expEv_t;

    localparam int DEBOUNCE = 4;
    localparam int LATENCY  = DEBOUNCE + 3;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    logic btnRaw = 1'b0;
    logic btnAl = 1'b1;

    logic pressPulse, releasePulse, btnLevel;
    logic pressAl, releaseAl, levelAl;

    int edgeCnt = 0;
    int errorCount = 0;
    int checkCount = 0;

    expEv_t expQ[$];
    expEv_t expQAl[$];

    button_pulse_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE),
        .ACTIVE_LOW_BTN  (1'b0)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rstN),
        .i_btn_raw       (btnRaw),
        .o_press_pulse   (pressPulse),
        .o_release_pulse (releasePulse),
        .o_btn_level     (btnLevel)
    );

    button_pulse_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE),
        .ACTIVE_LOW_BTN  (1'b1)
    ) dutAl (
        .i_clk           (clk),
        .i_rst_n         (rstN),
        .i_btn_raw       (btnAl),
        .o_press_pulse   (pressAl),
        .o_release_pulse (releaseAl),
        .o_btn_level     (levelAl)
    );

    // Free-running clock plus an edge index used to time-stamp expected events
    always #5 clk = ~clk;

    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    // Single comparison point: counts every check and reports any miss with its tag
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        assert (observed === expected)
        else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive both buttons and reset at a falling edge and hold them for n rising edges;
    // a requested event is queued as due LATENCY edges after the drive point
    task automatic applyStimulus(input logic b, input logic bAl, input logic r, input int n,
                                 input evKind_t ev, input evKind_t evAl);
        expEv_t e;
        @(negedge clk);
        btnRaw = b;
        btnAl  = bAl;
        rstN   = r;
        if (ev != EV_NONE) begin
            e.kind    = ev;
            e.edgeNum = edgeCnt + LATENCY;
            expQ.push_back(e);
        end
        if (evAl != EV_NONE) begin
            e.kind    = evAl;
            e.edgeNum = edgeCnt + LATENCY;
            expQAl.push_back(e);
        end
        repeat (n - 1) @(negedge clk);
    endtask

    // Match every pulse from the active-high instance against the scoreboard
    always @(negedge clk) begin
        expEv_t  e;
        evKind_t obs;
        if (pressPulse || releasePulse) begin
            obs = pressPulse ? EV_PRESS : EV_RELEASE;
            checkOutput("mainExclusive", int'(pressPulse & releasePulse), 0);
            if (expQ.size() == 0) begin
                checkOutput("mainUnexpectedPulseEdge", edgeCnt, -1);
            end else begin
                e = expQ.pop_front();
                checkOutput("mainKind", int'(obs), int'(e.kind));
                checkOutput("mainEdge", edgeCnt, e.edgeNum);
                checkOutput("mainLevelAtPulse", int'(btnLevel), int'(e.kind == EV_PRESS));
            end
        end
    end

    // Same matching for the active-low instance
    always @(negedge clk) begin
        expEv_t  e;
        evKind_t obs;
        if (pressAl || releaseAl) begin
            obs = pressAl ? EV_PRESS : EV_RELEASE;
            checkOutput("alExclusive", int'(pressAl & releaseAl), 0);
            if (expQAl.size() == 0) begin
                checkOutput("alUnexpectedPulseEdge", edgeCnt, -1);
            end else begin
                e = expQAl.pop_front();
                checkOutput("alKind", int'(obs), int'(e.kind));
                checkOutput("alEdge", edgeCnt, e.edgeNum);
                checkOutput("alLevelAtPulse", int'(levelAl), int'(e.kind == EV_PRESS));
            end
        end
    end

    // Directed sequence: reset, clean press, bounce, resets mid-event, polarity, back-to-back
    initial begin
        logic [6:0] bouncePat;
        bouncePat = 7'b1110110;
        $display("[TB] starting button_pulse_conditioner bench, DEBOUNCE_CYCLES=%0d", DEBOUNCE);

        applyStimulus(1'b1, 1'b1, 1'b0, 3, EV_NONE, EV_NONE);
        checkOutput("resetPress", int'(pressPulse), 0);
        checkOutput("resetRelease", int'(releasePulse), 0);
        checkOutput("resetLevel", int'(btnLevel), 0);
        checkOutput("resetLevelAl", int'(levelAl), 0);

        applyStimulus(1'b1, 1'b1, 1'b1, 12, EV_PRESS, EV_NONE);
        checkOutput("heldThroughResetLevel", int'(btnLevel), 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 12, EV_RELEASE, EV_NONE);
        checkOutput("heldThroughResetRelLevel", int'(btnLevel), 0);

        applyStimulus(1'b1, 1'b1, 1'b1, 7, EV_PRESS, EV_NONE);
        checkOutput("cleanLevelBeforeAccept", int'(btnLevel), 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 13, EV_NONE, EV_NONE);
        checkOutput("cleanLevelHeld", int'(btnLevel), 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 7, EV_RELEASE, EV_NONE);
        checkOutput("cleanLevelBeforeRelease", int'(btnLevel), 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 5, EV_NONE, EV_NONE);
        checkOutput("cleanLevelReleased", int'(btnLevel), 0);

        for (int i = 6; i >= 0; i--) begin
            applyStimulus(bouncePat[i], 1'b1, 1'b1, 1, EV_NONE, EV_NONE);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 10, EV_NONE, EV_NONE);
        checkOutput("bounceLevel", int'(btnLevel), 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 12, EV_PRESS, EV_NONE);
        checkOutput("afterBounceLevel", int'(btnLevel), 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 3, EV_NONE, EV_NONE);
        applyStimulus(1'b1, 1'b1, 1'b1, 8, EV_NONE, EV_NONE);
        checkOutput("releaseBounceLevel", int'(btnLevel), 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 12, EV_RELEASE, EV_NONE);
        checkOutput("afterReleaseBounceLevel", int'(btnLevel), 0);

        applyStimulus(1'b1, 1'b1, 1'b1, 5, EV_NONE, EV_NONE);
        applyStimulus(1'b1, 1'b1, 1'b0, 2, EV_NONE, EV_NONE);
        checkOutput("resetPressWaitLevel", int'(btnLevel), 0);
        checkOutput("resetPressWaitPulse", int'(pressPulse), 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 12, EV_PRESS, EV_NONE);
        checkOutput("requalifyLevel", int'(btnLevel), 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 3, EV_NONE, EV_NONE);
        checkOutput("resetPressedLevel", int'(btnLevel), 0);
        checkOutput("resetPressedRelease", int'(releasePulse), 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 12, EV_PRESS, EV_NONE);
        checkOutput("requalifyAgainLevel", int'(btnLevel), 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 12, EV_RELEASE, EV_NONE);

        applyStimulus(1'b0, 1'b0, 1'b1, 10, EV_NONE, EV_PRESS);
        checkOutput("activeLowPressedLevel", int'(levelAl), 1);
        checkOutput("activeHighUntouched", int'(btnLevel), 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 12, EV_NONE, EV_RELEASE);
        checkOutput("activeLowReleasedLevel", int'(levelAl), 0);

        applyStimulus(1'b1, 1'b1, 1'b1, 10, EV_PRESS, EV_NONE);
        applyStimulus(1'b0, 1'b1, 1'b1, 6, EV_RELEASE, EV_NONE);
        applyStimulus(1'b1, 1'b1, 1'b1, 10, EV_PRESS, EV_NONE);
        checkOutput("backToBackLevel", int'(btnLevel), 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 12, EV_RELEASE, EV_NONE);
        checkOutput("backToBackFinalLevel", int'(btnLevel), 0);

        repeat (3) @(negedge clk);
        checkOutput("mainPendingEvents", expQ.size(), 0);
        checkOutput("alPendingEvents", expQAl.size(), 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
